// File: rtl/rv32i_types.sv
// Shared rv32i types for the MEM stage: load/store funct3 encodings and the
// data-memory access FSM state.
package rv32i_types;

   typedef enum logic [2:0] {
      lb  = 3'b000,
      lh  = 3'b001,
      lw  = 3'b010,
      lbu = 3'b100,
      lhu = 3'b101
   } load_funct3_t;

   typedef enum logic [2:0] {
      sb = 3'b000,
      sh = 3'b001,
      sw = 3'b010
   } store_funct3_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } mem_access_state_t;

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic: store data/byte-enable alignment, legality check,
// and load byte-lane extraction with sign/zero extension.
module mem_align
   import rv32i_types::*;
(
   input  logic        req_read_i,
   input  logic        req_write_i,
   input  logic [2:0]  req_funct3_i,
   input  logic [1:0]  req_off_i,
   input  logic [31:0] req_wdata_i,
   output logic [31:0] req_wdata_o,
   output logic [3:0]  req_mbe_o,
   output logic        req_fault_o,
   input  logic [2:0]  rsp_funct3_i,
   input  logic [1:0]  rsp_off_i,
   input  logic [31:0] rsp_rdata_i,
   output logic [31:0] rsp_data_o
);

   logic [31:0] rsp_shifted;

   always_comb begin
      req_wdata_o = req_wdata_i << {req_off_i, 3'b000};
      req_mbe_o   = 4'b1111;
      req_fault_o = 1'b0;
      if (req_read_i && req_write_i) begin
         req_fault_o = 1'b1;
      end else if (req_read_i) begin
         case (load_funct3_t'(req_funct3_i))
            lb, lbu: req_fault_o = 1'b0;
            lh, lhu: req_fault_o = req_off_i[0];
            lw:      req_fault_o = |req_off_i;
            default: req_fault_o = 1'b1;
         endcase
      end else if (req_write_i) begin
         case (store_funct3_t'(req_funct3_i))
            sb: req_mbe_o = 4'b0001 << req_off_i;
            sh: begin
               req_mbe_o   = 4'b0011 << req_off_i;
               req_fault_o = req_off_i[0];
            end
            sw:      req_fault_o = |req_off_i;
            default: req_fault_o = 1'b1;
         endcase
      end
   end

   always_comb begin
      rsp_shifted = rsp_rdata_i >> {rsp_off_i, 3'b000};
      case (load_funct3_t'(rsp_funct3_i))
         lb:      rsp_data_o = {{24{rsp_shifted[7]}}, rsp_shifted[7:0]};
         lh:      rsp_data_o = {{16{rsp_shifted[15]}}, rsp_shifted[15:0]};
         lbu:     rsp_data_o = {24'd0, rsp_shifted[7:0]};
         lhu:     rsp_data_o = {16'd0, rsp_shifted[15:0]};
         default: rsp_data_o = rsp_shifted;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access controller: issues one cache request per live
// load/store, stalls the pipeline until the response, then pulses done_o.
module mem_access_unit
   import rv32i_types::*;
#(
   parameter int unsigned width = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mem_valid_i,
   input  logic             mem_read_i,
   input  logic             mem_write_i,
   input  logic [2:0]       mem_funct3_i,
   input  logic [width-1:0] mem_addr_i,
   input  logic [width-1:0] mem_wdata_i,
   input  logic [width-1:0] dmem_rdata_i,
   input  logic             dmem_resp_i,
   output logic             dmem_read_o,
   output logic             dmem_write_o,
   output logic [width-1:0] dmem_address_o,
   output logic [width-1:0] dmem_wdata_o,
   output logic [3:0]       dmem_mbe_o,
   output logic [width-1:0] load_data_o,
   output logic             done_o,
   output logic             stall_o,
   output logic             fault_o,
   output logic [31:0]      stall_cycles_o
);

   mem_access_state_t state_q;
   logic              read_q, write_q;
   logic [width-1:0]  addr_q, wdata_q, load_data_q;
   logic [3:0]        mbe_q;
   logic [2:0]        funct3_q;
   logic [1:0]        off_q;
   logic [31:0]       stall_cnt_q, stall_cnt_d;

   logic              mem_op, start;
   logic [31:0]       align_wdata, align_load;
   logic [3:0]        align_mbe;
   logic              align_fault;

   mem_align u_align (
      .req_read_i   (mem_read_i),
      .req_write_i  (mem_write_i),
      .req_funct3_i (mem_funct3_i),
      .req_off_i    (mem_addr_i[1:0]),
      .req_wdata_i  (mem_wdata_i),
      .req_wdata_o  (align_wdata),
      .req_mbe_o    (align_mbe),
      .req_fault_o  (align_fault),
      .rsp_funct3_i (funct3_q),
      .rsp_off_i    (off_q),
      .rsp_rdata_i  (dmem_rdata_i),
      .rsp_data_o   (align_load)
   );

   // Faults and starts are only recognised in IDLE; WAIT/DONE use the registered copy.
   always_comb begin
      mem_op      = mem_valid_i & (mem_read_i | mem_write_i);
      start       = (state_q == IDLE) && mem_op && !align_fault;
      fault_o     = (state_q == IDLE) && mem_op && align_fault;
      stall_o     = start || (state_q == WAIT);
      done_o      = (state_q == DONE);
      stall_cnt_d = stall_o ? stall_cnt_q + 32'd1 : stall_cnt_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         read_q      <= 1'b0;
         write_q     <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         mbe_q       <= 4'b0000;
         funct3_q    <= 3'b000;
         off_q       <= 2'b00;
         load_data_q <= '0;
         stall_cnt_q <= 32'd0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         case (state_q)
            IDLE: begin
               if (start) begin
                  read_q   <= mem_read_i;
                  write_q  <= mem_write_i;
                  addr_q   <= {mem_addr_i[width-1:2], 2'b00};
                  wdata_q  <= align_wdata;
                  mbe_q    <= align_mbe;
                  funct3_q <= mem_funct3_i;
                  off_q    <= mem_addr_i[1:0];
                  state_q  <= WAIT;
               end
            end
            WAIT: begin
               if (dmem_resp_i) begin
                  if (read_q) load_data_q <= align_load;
                  read_q  <= 1'b0;
                  write_q <= 1'b0;
                  state_q <= DONE;
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign dmem_read_o    = read_q;
   assign dmem_write_o   = write_q;
   assign dmem_address_o = addr_q;
   assign dmem_wdata_o   = wdata_q;
   assign dmem_mbe_o     = mbe_q;
   assign load_data_o    = load_data_q;
   assign stall_cycles_o = stall_cnt_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: hand-computed loads, stores, faults,
// reset-in-flight and back-to-back accesses against a simple cache responder.
module tb_mem_access_unit;

   logic        clk;
   logic        rst;
   logic        mem_valid_i, mem_read_i, mem_write_i;
   logic [2:0]  mem_funct3_i;
   logic [31:0] mem_addr_i, mem_wdata_i, dmem_rdata_i;
   logic        dmem_resp_i;
   logic        dmem_read_o, dmem_write_o;
   logic [31:0] dmem_address_o, dmem_wdata_o, load_data_o;
   logic [3:0]  dmem_mbe_o;
   logic        done_o, stall_o, fault_o;
   logic [31:0] stall_cycles_o;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] exp_q[$];

   mem_access_unit #(.width(32)) dut (
      .clk            (clk),
      .rst            (rst),
      .mem_valid_i    (mem_valid_i),
      .mem_read_i     (mem_read_i),
      .mem_write_i    (mem_write_i),
      .mem_funct3_i   (mem_funct3_i),
      .mem_addr_i     (mem_addr_i),
      .mem_wdata_i    (mem_wdata_i),
      .dmem_rdata_i   (dmem_rdata_i),
      .dmem_resp_i    (dmem_resp_i),
      .dmem_read_o    (dmem_read_o),
      .dmem_write_o   (dmem_write_o),
      .dmem_address_o (dmem_address_o),
      .dmem_wdata_o   (dmem_wdata_o),
      .dmem_mbe_o     (dmem_mbe_o),
      .load_data_o    (load_data_o),
      .done_o         (done_o),
      .stall_o        (stall_o),
      .fault_o        (fault_o),
      .stall_cycles_o (stall_cycles_o)
   );

   // clock/reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic drive_idle();
      mem_valid_i  = 1'b0;
      mem_read_i   = 1'b0;
      mem_write_i  = 1'b0;
      mem_funct3_i = 3'b000;
      mem_addr_i   = 32'd0;
      mem_wdata_i  = 32'd0;
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_rd"},    {31'd0, dmem_read_o},  32'd0);
      check_eq({tag, "_wr"},    {31'd0, dmem_write_o}, 32'd0);
      check_eq({tag, "_addr"},  dmem_address_o,        32'd0);
      check_eq({tag, "_wdata"}, dmem_wdata_o,          32'd0);
      check_eq({tag, "_mbe"},   {28'd0, dmem_mbe_o},   32'd0);
      check_eq({tag, "_ld"},    load_data_o,           32'd0);
      check_eq({tag, "_done"},  {31'd0, done_o},       32'd0);
      check_eq({tag, "_stall"}, {31'd0, stall_o},      32'd0);
      check_eq({tag, "_fault"}, {31'd0, fault_o},      32'd0);
      check_eq({tag, "_scnt"},  stall_cycles_o,        32'd0);
   endtask

   // One access: instruction held in IDLE cycle, inputs scrambled while waiting,
   // resp pulsed in WAIT cycle number resp_wait (1 = first WAIT cycle).
   task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] rdata, input int resp_wait,
                            output int stall_n, output int req_n, output int done_n,
                            output int chg_n, output logic [31:0] ld,
                            output logic [31:0] a_seen, output logic [31:0] w_seen,
                            output logic [3:0] m_seen);
      bit first = 1'b1;
      bit fin   = 1'b0;
      stall_n = 0; req_n = 0; done_n = 0; chg_n = 0;
      ld = 32'd0; a_seen = 32'd0; w_seen = 32'd0; m_seen = 4'd0;
      @(posedge clk); #1;
      mem_valid_i  = 1'b1;
      mem_read_i   = rd;
      mem_write_i  = wr;
      mem_funct3_i = f3;
      mem_addr_i   = addr;
      mem_wdata_i  = wd;
      dmem_rdata_i = rdata;
      dmem_resp_i  = 1'b0;
      for (int cyc = 0; cyc < 20 && !fin; cyc++) begin
         if (cyc > 0) begin
            @(posedge clk); #1;
            dmem_resp_i = (cyc == resp_wait);
            if (cyc == 1) begin
               mem_valid_i  = 1'b0;
               mem_addr_i   = $urandom;
               mem_wdata_i  = $urandom;
               mem_funct3_i = 3'($urandom_range(0, 7));
            end
         end
         @(negedge clk);
         stall_n += int'(stall_o);
         if (dmem_read_o || dmem_write_o) begin
            req_n++;
            if (first) begin
               a_seen = dmem_address_o;
               w_seen = dmem_wdata_o;
               m_seen = dmem_mbe_o;
               first  = 1'b0;
            end else if (a_seen != dmem_address_o || w_seen != dmem_wdata_o ||
                         m_seen != dmem_mbe_o) begin
               chg_n++;
            end
         end
         if (done_o) begin
            done_n++;
            ld  = load_data_o;
            fin = 1'b1;
         end
      end
      dmem_resp_i = 1'b0;
   endtask

   task automatic fault_case(input string tag, input logic rd, input logic wr,
                             input logic [2:0] f3, input logic [31:0] addr);
      @(posedge clk); #1;
      mem_valid_i  = 1'b1;
      mem_read_i   = rd;
      mem_write_i  = wr;
      mem_funct3_i = f3;
      mem_addr_i   = addr;
      @(negedge clk);
      check_eq({tag, "_fault"}, {31'd0, fault_o},                     32'd1);
      check_eq({tag, "_stall"}, {31'd0, stall_o},                     32'd0);
      check_eq({tag, "_req"},   {31'd0, dmem_read_o | dmem_write_o},  32'd0);
      @(posedge clk); #1;
      drive_idle();
      @(negedge clk);
      check_eq({tag, "_req_after"},   {31'd0, dmem_read_o | dmem_write_o}, 32'd0);
      check_eq({tag, "_fault_after"}, {31'd0, fault_o},                    32'd0);
   endtask

   int          s_n, r_n, d_n, c_n;
   logic [31:0] ld_v, a_v, w_v;
   logic [3:0]  m_v;

   initial begin
      drive_idle();
      dmem_rdata_i = 32'd0;
      dmem_resp_i  = 1'b0;
      rst = 1'b1;
      #2 rst = 1'b0;
      @(negedge clk);
      check_all_zero("reset");
      @(posedge clk); #1 rst = 1'b1;

      // LW 0x1000, three WAIT cycles
      exp_q.push_back(32'hDEADBEEF);
      do_access(1'b1, 1'b0, 3'b010, 32'h0000_1000, 32'd0, 32'hDEADBEEF, 3,
                s_n, r_n, d_n, c_n, ld_v, a_v, w_v, m_v);
      check_eq("lw_addr",  a_v, 32'h0000_1000);
      check_eq("lw_mbe",   {28'd0, m_v}, 32'hF);
      check_eq("lw_stall", s_n, 32'd4);
      check_eq("lw_req",   r_n, 32'd3);
      check_eq("lw_done",  d_n, 32'd1);
      check_eq("lw_data",  ld_v, exp_q.pop_front());
      check_eq("lw_scnt",  stall_cycles_o, 32'd4);
      @(negedge clk);
      check_eq("lw_done_once", {31'd0, done_o},  32'd0);
      check_eq("lw_idle_stall", {31'd0, stall_o}, 32'd0);

      // LB / LBU at 0x2003, byte lane 3 = 0x80
      exp_q.push_back(32'hFFFF_FF80);
      do_access(1'b1, 1'b0, 3'b000, 32'h0000_2003, 32'd0, 32'h80FF_0000, 1,
                s_n, r_n, d_n, c_n, ld_v, a_v, w_v, m_v);
      check_eq("lb_addr",  a_v, 32'h0000_2000);
      check_eq("lb_stall", s_n, 32'd2);
      check_eq("lb_data",  ld_v, exp_q.pop_front());
      exp_q.push_back(32'h0000_0080);
      do_access(1'b1, 1'b0, 3'b100, 32'h0000_2003, 32'd0, 32'h80FF_0000, 1,
                s_n, r_n, d_n, c_n, ld_v, a_v, w_v, m_v);
      check_eq("lbu_mbe",  {28'd0, m_v}, 32'hF);
      check_eq("lbu_done", d_n, 32'd1);
      check_eq("lbu_data", ld_v, exp_q.pop_front());

      // SH at 0x3002, upper half lanes, write held two WAIT cycles
      do_access(1'b0, 1'b1, 3'b001, 32'h0000_3002, 32'h0000_ABCD, 32'h5555_5555, 2,
                s_n, r_n, d_n, c_n, ld_v, a_v, w_v, m_v);
      check_eq("sh_addr",  a_v, 32'h0000_3000);
      check_eq("sh_wdata", w_v, 32'hABCD_0000);
      check_eq("sh_mbe",   {28'd0, m_v}, 32'hC);
      check_eq("sh_req",   r_n, 32'd2);
      check_eq("sh_hold",  c_n, 32'd0);
      check_eq("sh_stall", s_n, 32'd3);
      check_eq("sh_ld_kept", ld_v, 32'h0000_0080);
      check_eq("sh_scnt",  stall_cycles_o, 32'd11);

      // illegal / misaligned accesses
      fault_case("lh_mis",  1'b1, 1'b0, 3'b001, 32'h0000_4001);
      fault_case("ld_f011", 1'b1, 1'b0, 3'b011, 32'h0000_4000);
      fault_case("rw_both", 1'b1, 1'b1, 3'b010, 32'h0000_4000);
      fault_case("sw_mis",  1'b0, 1'b1, 3'b010, 32'h0000_4002);
      check_eq("fault_scnt", stall_cycles_o, 32'd11);

      // reset while a load is outstanding
      @(posedge clk); #1;
      mem_valid_i = 1'b1; mem_read_i = 1'b1; mem_write_i = 1'b0;
      mem_funct3_i = 3'b010; mem_addr_i = 32'h0000_5000;
      @(negedge clk);
      @(posedge clk); #1;
      drive_idle();
      @(negedge clk);
      check_eq("rst_pre_rd", {31'd0, dmem_read_o}, 32'd1);
      #2 rst = 1'b0;
      #1 check_all_zero("rst_wait");
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 dmem_rdata_i = 32'h1234_5678; dmem_resp_i = 1'b1;
      @(negedge clk);
      check_eq("late_resp_stall", {31'd0, stall_o}, 32'd0);
      @(posedge clk); #1 dmem_resp_i = 1'b0;
      @(negedge clk);
      check_eq("late_resp_done", {31'd0, done_o},      32'd0);
      check_eq("late_resp_rd",   {31'd0, dmem_read_o}, 32'd0);
      check_eq("late_resp_ld",   load_data_o,          32'd0);

      // back-to-back SW then LW with same-cycle response
      do_access(1'b0, 1'b1, 3'b010, 32'h0000_6000, 32'h1234_5678, 32'd0, 1,
                s_n, r_n, d_n, c_n, ld_v, a_v, w_v, m_v);
      check_eq("b2b_sw_wdata", w_v, 32'h1234_5678);
      check_eq("b2b_sw_mbe",   {28'd0, m_v}, 32'hF);
      check_eq("b2b_sw_stall", s_n, 32'd2);
      check_eq("b2b_sw_req",   r_n, 32'd1);
      check_eq("b2b_sw_done",  d_n, 32'd1);
      exp_q.push_back(32'hCAFE_F00D);
      do_access(1'b1, 1'b0, 3'b010, 32'h0000_6000, 32'd0, 32'hCAFE_F00D, 1,
                s_n, r_n, d_n, c_n, ld_v, a_v, w_v, m_v);
      check_eq("b2b_lw_stall", s_n, 32'd2);
      check_eq("b2b_lw_req",   r_n, 32'd1);
      check_eq("b2b_lw_data",  ld_v, exp_q.pop_front());
      check_eq("b2b_scnt",     stall_cycles_o, 32'd4);

      // non-memory instruction passes with no stall
      @(posedge clk); #1;
      mem_valid_i = 1'b1; mem_read_i = 1'b0; mem_write_i = 1'b0;
      @(negedge clk);
      check_eq("nonmem_stall", {31'd0, stall_o}, 32'd0);
      check_eq("nonmem_req",   {31'd0, dmem_read_o | dmem_write_o}, 32'd0);
      check_eq("nonmem_done",  {31'd0, done_o}, 32'd0);
      @(posedge clk); #1 drive_idle();
      @(negedge clk);
      check_eq("final_scnt", stall_cycles_o, 32'd4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage data-memory access controller of the rv32i pipeline.
- Consumes the EX/MEM register outputs (ALU result as address, rs2 as store data, control word) and drives the data-cache request/response handshake.
- Aligns store data and byte enables, and sign/zero-extends load data.
- Stalls the pipeline until the access completes.

Parameters:
- width, 32, data/address word width (only 32 supported)

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-low reset
- mem_valid_i  in  1  EX/MEM register holds a live instruction
- mem_read_i  in  1  instruction is a load
- mem_write_i  in  1  instruction is a store
- mem_funct3_i  in  3  load/store size and sign (rv32i funct3)
- mem_addr_i  in  width  byte address (EX ALU output)
- mem_wdata_i  in  width  store data (EX rs2 output)
- dmem_rdata_i  in  width  read data from data cache
- dmem_resp_i  in  1  data cache response, one-cycle pulse
- dmem_read_o  out  1  read request
- dmem_write_o  out  1  write request
- dmem_address_o  out  width  word-aligned address ({addr[31:2],2'b00})
- dmem_wdata_o  out  width  lane-shifted store data
- dmem_mbe_o  out  4  byte enables
- load_data_o  out  width  extended load result, valid when done_o=1
- done_o  out  1  access completed this cycle; pipeline may advance
- stall_o  out  1  freeze IF..MEM registers
- fault_o  out  1  misaligned or illegal funct3; one-cycle pulse, no access issued
- stall_cycles_o  out  32  count of cycles with stall_o=1, wraps at 2^32

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0, including load_data_o and stall_cycles_o. Any in-flight request is dropped immediately. A late dmem_resp_i after reset is ignored.
- mem_op = mem_valid_i & (mem_read_i | mem_write_i). Both read and write set: treat as fault.
- Offset off = mem_addr_i[1:0].
  - Legal loads: LB 000, LH 001, LW 010, LBU 100, LHU 101.
  - Legal stores: SB 000, SH 001, SW 010.
  - Misaligned: half-word with off[0]=1, or word with off!=0. Other funct3 values are illegal.
- Store encoding:
  - dmem_wdata_o = mem_wdata_i << (8*off).
  - mbe: SB 4'b0001<<off; SH 4'b0011<<off; SW 4'b1111.
  - Loads drive mbe 4'b1111.
- Load extraction from dmem_rdata_i >> (8*off):
  - LB/LH: sign-extend bit 7/15.
  - LBU/LHU: zero-extend.
  - LW: pass through.
- FSM states: IDLE, WAIT, DONE.
  - IDLE, mem_op=0: stall_o=0, done_o=0. Non-memory instructions pass with zero added latency.
  - IDLE, mem_op=1 and fault: fault_o=1 for one cycle, stall_o=0, no request; stay IDLE.
  - IDLE, mem_op=1 and legal: stall_o=1 combinationally. Register address, wdata, mbe, funct3 and off; assert dmem_read_o or dmem_write_o from the next cycle; go to WAIT.
  - WAIT: request outputs held stable and stall_o=1 until dmem_resp_i. On resp: capture the extended load data into load_data_o, deassert the request the same edge, go to DONE.
  - DONE: stall_o=0, done_o=1 for exactly one cycle, load_data_o valid. Next state is IDLE. The EX/MEM register advances on this edge, so the same instruction is never reissued.
- dmem_resp_i in IDLE or DONE: ignored.
- Minimum memory-op latency: request in cycle 1, resp in cycle 1, done_o in cycle 2.
- Inputs may change in WAIT; the registered copies are used.
- load_data_o holds its last value until the next load completes. Stores leave it unchanged.
- stall_cycles_o increments every cycle stall_o=1, wrapping.

Decomposition:
- rv32i_types package gets a new load_funct3_t enum (lb, lh, lw, lbu, lhu) and a store_funct3_t enum (sb, sh, sw).
- The package also gets an enum mem_access_state_t {IDLE, WAIT, DONE}.
- One combinational sub-module, mem_align: store shift/mbe, load extract/extend, and fault detection. The FSM, registers and counter stay in mem_access_unit.

Test Plan:
- LW at 0x1000, cache responds after 3 WAIT cycles with 0xDEADBEEF:
  - request asserted with address 0x1000, mbe 1111;
  - stall_o high for 4 cycles;
  - done_o pulses once with load_data_o=0xDEADBEEF;
  - stall_cycles_o=4.
- LB and LBU at 0x2003 with rdata 0x80FF_0000:
  - LB returns 0xFFFFFF80;
  - LBU returns 0x00000080.
- SH at 0x3002 with rs2=0x0000ABCD: dmem_wdata_o=0xABCD0000, mbe 1100, write held until resp.
- LH at 0x4001, then funct3 011 load: each gives a fault_o pulse, no dmem_read_o, stall_o=0.
- Reset in WAIT with dmem_read_o=1: outputs 0 immediately; a resp arriving after reset release is ignored and the FSM stays in IDLE.
- Back-to-back SW then LW with 0-latency resp: each completes in 2 cycles with no duplicate request; a non-memory instruction passes with zero stall.
